// File: rtl/mips_mc_control_fsm.sv
// rtl/mips_mc_control_fsm.sv - main control FSM of the multicycle MIPS core
//
// Sequences the shared multicycle datapath. Each state drives the datapath mux
// selects, the register write enables and ALUOp. The FSM waits in the memory
// states until the memory ready handshake completes.
//
// Ports:
//   clk        - clock; all state changes happen on the rising edge
//   rst_n      - synchronous active-low reset
//   op         - opcode from the instruction register
//   mem_ready  - memory access complete (qualified by mem_req)
//   mem_req    - memory access request
//   iord       - address mux select: 0 = PC, 1 = ALUOut
//   mem_write  - memory write strobe
//   ir_write   - instruction register load
//   pc_write   - unconditional PC load
//   branch     - conditional PC load (datapath ANDs it with zero)
//   reg_dst    - write register select: 0 = rt, 1 = rd
//   mem_to_reg - write data select: 0 = ALUOut, 1 = MDR
//   reg_write  - register file write enable
//   alu_src_a  - ALU A select: 0 = PC, 1 = A
//   alu_src_b  - ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
//   alu_op     - 00 = add, 01 = sub, 10 = use funct
//   pc_src     - PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
//   illegal_op - one-cycle pulse when DECODE sees an unknown opcode
//   state_o    - current state code (debug)
module mips_mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC+4 load only on the cycle the instruction word arrives.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        // Branch target is precomputed here, speculatively, into ALUOut.
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)        state_d = S_EXEC;
        else if (op == OP_BEQ)          state_d = S_BRANCH;
        else if (op == OP_ADDI)         state_d = S_ADDIEX;
        else if (op == OP_J)            state_d = S_JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      // Unused codes recover by restarting instruction fetch.
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// tb/tb_mips_mc_control_fsm.sv - self-checking bench for mips_mc_control_fsm
module tb_mips_mc_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BAD   = 6'h3F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req, iord, mem_write, ir_write, pc_write, branch;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;

  mips_mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [16:0] dut_vec;
  assign dut_vec = {mem_req, iord, mem_write, ir_write, pc_write, branch,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                    alu_op, pc_src, illegal_op};

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected control word for a state, written from the per-state output rules.
  function automatic logic [16:0] exp_vec(input int s, input logic mr, input logic [5:0] o);
    logic mrq, io, mw, irw, pcw, br, rd, m2r, rw, sa, ill;
    logic [1:0] sb, aop, ps;
    {mrq, io, mw, irw, pcw, br, rd, m2r, rw, sa, ill} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (s)
      1:  begin mrq = 1; sb = 2'b01; irw = mr; pcw = mr; end
      2:  begin
            sb  = 2'b11;
            ill = !(o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
          end
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin mrq = 1; io = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mrq = 1; io = 1; mw = 1; end
      7:  begin sa = 1; aop = 2'b10; end
      8:  begin rd = 1; rw = 1; end
      9:  begin sa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
      10: begin sa = 1; sb = 2'b10; end
      11: begin rw = 1; end
      12: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {mrq, io, mw, irw, pcw, br, rd, m2r, rw, sa, sb, aop, ps, ill};
  endfunction

  // Model: the route an instruction takes after DECODE, as a list of states.
  int m_state = 0;
  bit m_valid = 0;
  int route[$];
  int ridx = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("state", int'(state_o), m_state);
      check("ctrl", int'(dut_vec), int'(exp_vec(m_state, mem_ready, op)));
      check("write_excl", int'(ir_write) + int'(reg_write) + int'(mem_write) <= 1, 1);
    end
    if (!rst_n) begin
      m_state = 0;
      m_valid = 1;
      route.delete();
    end else if (m_valid) begin
      if (m_state == 0) m_state = 1;
      else if ((m_state == 1 || m_state == 4 || m_state == 6) && !mem_ready) m_state = m_state;
      else if (m_state == 1) m_state = 2;
      else if (m_state == 2) begin
        route.delete();
        case (op)
          OP_LW:    route = '{3, 4, 5};
          OP_SW:    route = '{3, 6};
          OP_RTYPE: route = '{7, 8};
          OP_BEQ:   route = '{9};
          OP_ADDI:  route = '{10, 11};
          OP_J:     route = '{12};
          default:  route.delete();
        endcase
        ridx = 0;
        m_state = (route.size() == 0) ? 1 : route[0];
      end else begin
        ridx++;
        m_state = (ridx < route.size()) ? route[ridx] : 1;
      end
    end
  end

  // One cycle: drive inputs just after the edge, sample state at the falling edge.
  task automatic cyc(input logic r, input logic mr, input logic [5:0] o,
                     input int exp_s, input string nm);
    @(posedge clk);
    #1;
    rst_n = r; mem_ready = mr; op = o;
    @(negedge clk);
    if (exp_s >= 0) check(nm, int'(state_o), exp_s);
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; op = OP_LW;
    // Reset for two edges, then release.
    cyc(0, 1, OP_LW, -1, "rst0");
    cyc(0, 1, OP_LW, 0, "rst_state");
    check("rst_outputs_zero", int'(dut_vec), 0);
    cyc(1, 1, OP_LW, 0, "rel_idle");
    check("idle_outputs_zero", int'(dut_vec), 0);
    // LW with mem_ready high: 1,2,3,4,5 then FETCH.
    cyc(1, 1, OP_LW, 1, "lw_fetch");
    check("lw_ir_write", int'(ir_write), 1);
    check("lw_pc_write", int'(pc_write), 1);
    cyc(1, 1, OP_LW, 2, "lw_decode");
    cyc(1, 1, OP_LW, 3, "lw_memadr");
    cyc(1, 1, OP_LW, 4, "lw_memrd");
    check("lw_memrd_regwrite", int'(reg_write), 0);
    cyc(1, 1, OP_LW, 5, "lw_memwb");
    check("lw_wb_regwrite", int'(reg_write), 1);
    check("lw_wb_memtoreg", int'(mem_to_reg), 1);
    // SW with three stalled cycles in MEMWR.
    cyc(1, 1, OP_SW, 1, "sw_fetch");
    cyc(1, 1, OP_SW, 2, "sw_decode");
    cyc(1, 1, OP_SW, 3, "sw_memadr");
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, OP_SW, 6, "sw_stall");
      check("sw_stall_memwrite", int'(mem_write), 1);
    end
    cyc(1, 1, OP_SW, 6, "sw_done");
    check("sw_done_memwrite", int'(mem_write), 1);
    // BEQ then J.
    cyc(1, 1, OP_BEQ, 1, "beq_fetch");
    cyc(1, 1, OP_BEQ, 2, "beq_decode");
    cyc(1, 1, OP_BEQ, 9, "beq_branch");
    check("beq_pc_src", int'(pc_src), 1);
    check("beq_branch_bit", int'(branch), 1);
    cyc(1, 1, OP_J, 1, "j_fetch");
    cyc(1, 1, OP_J, 2, "j_decode");
    cyc(1, 1, OP_J, 12, "j_jump");
    check("j_pc_src", int'(pc_src), 2);
    check("j_pc_write", int'(pc_write), 1);
    // Illegal opcode.
    cyc(1, 1, OP_BAD, 1, "ill_fetch");
    cyc(1, 1, OP_BAD, 2, "ill_decode");
    check("ill_pulse", int'(illegal_op), 1);
    check("ill_no_writes", int'({reg_write, mem_write, ir_write, pc_write}), 0);
    cyc(1, 1, OP_RTYPE, 1, "ill_back_fetch");
    check("ill_pulse_gone", int'(illegal_op), 0);
    // R-type then ADDI.
    cyc(1, 1, OP_RTYPE, 2, "r_decode");
    cyc(1, 1, OP_RTYPE, 7, "r_exec");
    check("r_alu_op", int'(alu_op), 2);
    cyc(1, 1, OP_RTYPE, 8, "r_aluwb");
    check("r_reg_dst", int'(reg_dst), 1);
    cyc(1, 1, OP_ADDI, 1, "addi_fetch");
    cyc(1, 1, OP_ADDI, 2, "addi_decode");
    cyc(1, 1, OP_ADDI, 10, "addi_ex");
    cyc(1, 1, OP_ADDI, 11, "addi_wb");
    check("addi_reg_dst", int'(reg_dst), 0);
    // Fetch stall, then reset while stalled in MEMRD.
    cyc(1, 0, OP_LW, 1, "stall_fetch");
    check("stall_no_ir_write", int'(ir_write), 0);
    cyc(1, 1, OP_LW, 1, "stall_fetch_done");
    check("stall_ir_write", int'(ir_write), 1);
    cyc(1, 1, OP_LW, 2, "s2_decode");
    cyc(1, 1, OP_LW, 3, "s2_memadr");
    cyc(1, 0, OP_LW, 4, "s2_memrd");
    cyc(0, 0, OP_LW, 4, "s2_memrd_rst");
    cyc(1, 1, OP_LW, 0, "mid_rst_idle");
    check("mid_rst_mem_req", int'(mem_req), 0);
    cyc(1, 1, OP_LW, 1, "mid_rst_fetch");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
